fft_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 single-path delay-feedback FFT stage. The stage datapath is
//  a DEPTH-deep vector shift buffer (IN_SIZE lanes, I/Q) plus a butterfly.

---
 rtl/fft_ctrl_pkg.sv | 17 +
 rtl/mod_counter.sv | 31 +++
 rtl/fft_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_fft_stage_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and sizing helpers for the FFT stage sequencer.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BFLY  = 2'd1,
    FLUSH = 2'd2
  } fft_st_e;

  // Counter width for a modulo-`modulus` counter; never less than one bit.
  function automatic int cnt_w(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and a wrap strobe.
// Latency: value updates on the clock edge after inc; wrap is combinational.
// Backpressure: none; counts only when inc is asserted.
module mod_counter
  import fft_ctrl_pkg::*;
#(
  parameter int MOD = 16,
  localparam int W  = cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  // Wrap marks the increment that takes the count from MOD-1 back to zero.
  always_comb begin
    wrap = inc && (value == W'(MOD - 1));
  end

  // Count register: clear has priority, then increment with modulo return.
  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: FILL/BFLY half-frames plus a FLUSH drain.
// Latency: strobes are combinational from state and din_valid; frame_done one cycle after last BFLY beat.
// Backpressure: din_ready drops only while draining; the flush-entry cycle ignores din_valid.
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int IN_SIZE = 16,
  parameter int FCNT_W  = 16,
  localparam int CW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              flush,
  output logic              buf_shift,
  output logic              buf_sel,
  output logic              bfly_en,
  output logic [CW-1:0]     tw_idx,
  output logic              dout_valid,
  output logic              dout_sel,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  // Parameter sanity: depth must be a power of two of at least 2, lanes at least 1.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (IN_SIZE < 1)) begin : g_param_chk
    $error("fft_stage_ctrl: DEPTH must be a power of two >= 2 and IN_SIZE >= 1");
  end

  fft_st_e       st;
  logic          pend;
  logic [CW-1:0] cnt;
  logic          cnt_wrap;
  logic          cnt_inc;
  logic          flush_go;
  logic          beat;

  // Drain starts only on a half-frame boundary with differences still buffered.
  // din_ready stays high in that cycle, but the beat is deliberately not taken.
  always_comb begin
    din_ready = (st != FLUSH);
    flush_go  = (st == FILL) && (cnt == '0) && pend && flush;
    beat      = din_valid && din_ready && !flush_go;
    cnt_inc   = beat || (st == FLUSH);
  end

  mod_counter #(.MOD(DEPTH)) u_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (cnt_inc),
    .value (cnt),
    .wrap  (cnt_wrap)
  );

  // Datapath strobes for the current cycle; all idle when nothing moves.
  always_comb begin
    buf_shift  = 1'b0;
    buf_sel    = 1'b0;
    bfly_en    = 1'b0;
    tw_idx     = '0;
    dout_valid = 1'b0;
    dout_sel   = 1'b0;
    case (st)
      FILL: begin
        if (beat) begin
          buf_shift  = 1'b1;
          dout_valid = pend;
          dout_sel   = pend;
        end
      end
      BFLY: begin
        if (beat) begin
          bfly_en    = 1'b1;
          tw_idx     = cnt;
          buf_shift  = 1'b1;
          buf_sel    = 1'b1;
          dout_valid = 1'b1;
        end
      end
      FLUSH: begin
        buf_shift  = 1'b1;
        dout_valid = 1'b1;
        dout_sel   = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase FSM with registered frame completion pulse and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= FILL;
      pend       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (st)
        FILL: begin
          if (flush_go) begin
            st <= FLUSH;
          end else if (cnt_wrap) begin
            st   <= BFLY;
            pend <= 1'b0;
          end
        end
        BFLY: begin
          if (cnt_wrap) begin
            st         <= FILL;
            pend       <= 1'b1;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_wrap) begin
            st   <= FILL;
            pend <= 1'b0;
          end
        end
        default: begin
          st <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl with DEPTH=16.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Each scenario task performs its own inline comparisons.
module tb_fft_stage_ctrl;

  localparam int DEPTH  = 16;
  localparam int FCNT_W = 16;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic        flush;
  logic        buf_shift;
  logic        buf_sel;
  logic        bfly_en;
  logic [3:0]  tw_idx;
  logic        dout_valid;
  logic        dout_sel;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_checks;
  int n_fail;

  // {din_ready, buf_shift, buf_sel, bfly_en, tw_idx, dout_valid, dout_sel}
  logic [9:0] obs;
  assign obs = {din_ready, buf_shift, buf_sel, bfly_en, tw_idx, dout_valid, dout_sel};

  fft_stage_ctrl #(.DEPTH(DEPTH), .IN_SIZE(16), .FCNT_W(FCNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .buf_shift  (buf_shift),
    .buf_sel    (buf_sel),
    .bfly_en    (bfly_en),
    .tw_idx     (tw_idx),
    .dout_valid (dout_valid),
    .dout_sel   (dout_sel),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    flush     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_beats(input int n);
    din_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    din_valid = 1'b0;
  endtask

  // 1: idle after reset
  task automatic test_reset();
    logic [9:0] exp_v;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_strobes cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      n_checks++;
      if (frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_frame cyc=%0d got done=%b cnt=%0d want done=0 cnt=0", i, frame_done, frame_cnt);
      end
      tick();
    end
  endtask

  // 2+3: 48 continuous beats: fill, butterfly, then differences out
  task automatic test_frame();
    logic [9:0]  exp_v;
    logic        exp_done;
    logic [15:0] exp_cnt;
    apply_reset();
    din_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i < 16)      exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      else if (i < 32) exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 4'(i - 16), 1'b1, 1'b0};
      else             exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1};
      exp_done = (i == 32);
      exp_cnt  = (i >= 32) ? 16'd1 : 16'd0;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL frame_strobes beat=%0d got=%b want=%b", i, obs, exp_v);
      end
      n_checks++;
      if (frame_done !== exp_done || frame_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL frame_done beat=%0d got done=%b cnt=%0d want done=%b cnt=%0d",
                 i, frame_done, frame_cnt, exp_done, exp_cnt);
      end
      tick();
    end
    din_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL frame_idle_after got=%b want=1000000000", obs);
    end
    tick();
  endtask

  // 4: flush drains 16 differences, then a fresh fill with no output
  task automatic test_flush();
    logic [9:0] exp_v;
    int         not_ready;
    apply_reset();
    run_beats(32);
    flush     = 1'b1;
    din_valid = 1'b1;
    not_ready = 0;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k == 0)       exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      else if (k <= 16) exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1};
      else if (k <= 32) exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      else              exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
      if (din_ready === 1'b0) not_ready++;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL flush_strobes cyc=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 0) begin
        n_checks++;
        if (frame_done !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_frame_done got=%b want=1", frame_done);
        end
      end
      tick();
    end
    flush     = 1'b0;
    din_valid = 1'b0;
    n_checks++;
    if (not_ready != 16) begin
      n_fail++;
      $display("FAIL flush_stall_len got=%0d want=16", not_ready);
    end
  endtask

  // 5: alternating valid, flush ignored in BFLY and mid-FILL
  task automatic test_gaps();
    logic [9:0] exp_v;
    int         b;
    apply_reset();
    for (int c = 0; c < 64; c++) begin
      b         = c / 2;
      din_valid = ((c % 2) == 0);
      flush     = (b >= 16) && (c < 63);
      @(negedge clk);
      if ((c % 2) == 1)  exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      else if (b < 16)   exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      else               exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 4'(b - 16), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL gaps_strobes cyc=%0d got=%b want=%b", c, obs, exp_v);
      end
      if (c == 63) begin
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
          n_fail++;
          $display("FAIL gaps_frame got done=%b cnt=%0d want done=1 cnt=1", frame_done, frame_cnt);
        end
      end
      tick();
    end
    // Five difference beats, then flush at cnt=5 must not stall input.
    flush = 1'b0;
    run_beats(5);
    flush     = 1'b1;
    din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL gaps_flush_mid cyc=%0d got=%b want=1100000011", k, obs);
      end
      tick();
    end
    flush     = 1'b0;
    din_valid = 1'b0;
  endtask

  // 6: reset in the middle of BFLY discards the partial frame
  task automatic test_reset_mid();
    logic [9:0] exp_v;
    apply_reset();
    run_beats(23);
    rst       = 1'b1;
    din_valid = 1'b1;
    tick();
    rst       = 1'b0;
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0} ||
          frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL rstmid_idle cyc=%0d got=%b done=%b cnt=%0d want=1000000000 done=0 cnt=0",
                 k, obs, frame_done, frame_cnt);
      end
      tick();
    end
    din_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i == 32) din_valid = 1'b0;
      @(negedge clk);
      if (i == 32)     exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      else if (i < 16) exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      else             exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 4'(i - 16), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_frame beat=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (i == 32) begin
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
          n_fail++;
          $display("FAIL rstmid_done got done=%b cnt=%0d want done=1 cnt=1", frame_done, frame_cnt);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    din_valid = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_frame();
    test_flush();
    test_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
